// File: rtl/tour_pkg.sv
// Shared constants and types for the knight's-tour command player:
// one-hot move encodings, motion headings, opcodes, responses and FSM states.
package tour_pkg;

  // One-hot moves, named by (dx,dy) with +x east, +y north
  localparam logic [7:0] MV_P1_P2 = 8'h01;
  localparam logic [7:0] MV_M1_P2 = 8'h02;
  localparam logic [7:0] MV_M2_P1 = 8'h04;
  localparam logic [7:0] MV_M2_M1 = 8'h08;
  localparam logic [7:0] MV_M1_M2 = 8'h10;
  localparam logic [7:0] MV_P1_M2 = 8'h20;
  localparam logic [7:0] MV_P2_M1 = 8'h40;
  localparam logic [7:0] MV_P2_P1 = 8'h80;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;

  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } tour_state_e;

endpackage

// File: rtl/tour_move_decode.sv
// Combinational split of a one-hot knight move into a vertical leg and a
// horizontal leg (heading + square count); flags anything not one-hot.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] vert_heading,
  output logic [3:0] vert_sq,
  output logic [7:0] horz_heading,
  output logic [3:0] horz_sq,
  output logic       illegal
);

  always_comb begin
    vert_heading = HDG_N;
    vert_sq      = 4'd0;
    horz_heading = HDG_E;
    horz_sq      = 4'd0;
    illegal      = 1'b0;
    case (move)
      MV_P1_P2: begin vert_heading = HDG_N; vert_sq = 4'd2; horz_heading = HDG_E; horz_sq = 4'd1; end
      MV_M1_P2: begin vert_heading = HDG_N; vert_sq = 4'd2; horz_heading = HDG_W; horz_sq = 4'd1; end
      MV_M2_P1: begin vert_heading = HDG_N; vert_sq = 4'd1; horz_heading = HDG_W; horz_sq = 4'd2; end
      MV_M2_M1: begin vert_heading = HDG_S; vert_sq = 4'd1; horz_heading = HDG_W; horz_sq = 4'd2; end
      MV_M1_M2: begin vert_heading = HDG_S; vert_sq = 4'd2; horz_heading = HDG_W; horz_sq = 4'd1; end
      MV_P1_M2: begin vert_heading = HDG_S; vert_sq = 4'd2; horz_heading = HDG_E; horz_sq = 4'd1; end
      MV_P2_M1: begin vert_heading = HDG_S; vert_sq = 4'd1; horz_heading = HDG_E; horz_sq = 4'd2; end
      MV_P2_P1: begin vert_heading = HDG_N; vert_sq = 4'd1; horz_heading = HDG_E; horz_sq = 4'd2; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/tour_cmd_player.sv
// Plays a solved knight's tour as vertical/horizontal motion commands, passing
// UART commands through when idle. Define TOUR_CMD_FANFARE_EN for fanfare horizontal legs.
// Handshake: cmd is offered while cmd_rdy=1; clr_cmd_rdy takes it, and send_resp
// later reports the motion finished, which releases the next command.
module tour_cmd_player
  import tour_pkg::*;
#(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp,
  output logic        tour_err,
  output tour_state_e state_dbg
);

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HORZ_OP = OP_FANFARE;
`else
  localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  tour_state_e state, nxt_state;
  logic [4:0]  nxt_indx;
  logic        nxt_tour_err;
  logic [7:0]  vert_heading, horz_heading;
  logic [3:0]  vert_sq, horz_sq;
  logic        illegal;
  logic        last_move;

  tour_move_decode u_decode (
    .move         (move),
    .vert_heading (vert_heading),
    .vert_sq      (vert_sq),
    .horz_heading (horz_heading),
    .horz_sq      (horz_sq),
    .illegal      (illegal)
  );

  assign last_move = (indx == LAST_INDX);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      indx     <= 5'd0;
      tour_err <= 1'b0;
    end else begin
      state    <= nxt_state;
      indx     <= nxt_indx;
      tour_err <= nxt_tour_err;
    end
  end

  always_comb begin
    nxt_state        = state;
    nxt_indx         = indx;
    nxt_tour_err     = 1'b0;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;
    case (state)
      IDLE: begin
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_IDLE;
        nxt_indx         = 5'd0;
        if (start_tour) nxt_state = VERT;
      end
      VERT: begin
        cmd = {OP_MOVE, vert_heading, vert_sq};
        // A corrupt move aborts the tour before anything is offered downstream
        if (illegal) begin
          nxt_state    = IDLE;
          nxt_indx     = 5'd0;
          nxt_tour_err = 1'b1;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) nxt_state = WAIT_V;
        end
      end
      WAIT_V: begin
        cmd = {OP_MOVE, vert_heading, vert_sq};
        if (send_resp) nxt_state = HORZ;
      end
      HORZ: begin
        cmd     = {HORZ_OP, horz_heading, horz_sq};
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) nxt_state = WAIT_H;
      end
      WAIT_H: begin
        cmd = {HORZ_OP, horz_heading, horz_sq};
        if (last_move) resp = RESP_IDLE;
        if (send_resp) begin
          if (last_move) begin
            nxt_state = IDLE;
            nxt_indx  = 5'd0;
          end else begin
            nxt_state = VERT;
            nxt_indx  = indx + 5'd1;
          end
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_indx  = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_player.sv
// Directed bench for tour_cmd_player: pass-through, leg splitting, a full
// 24-move tour, illegal-move abort and mid-tour reset.
module tb_tour_cmd_player;
  import tour_pkg::*;

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] H_OP = 4'h3;
`else
  localparam logic [3:0] H_OP = 4'h2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        tour_err;
  tour_state_e state_dbg;

  logic [7:0] mem [24];
  int n_cmp = 0;
  int n_bad = 0;
  int n_clr = 0;
  int n_send = 0;
  int dx_t [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int dy_t [8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  assign move = mem[indx];

  tour_cmd_player #(.NUM_MOVES(24)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_tour       (start_tour),
    .move             (move),
    .indx             (indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp),
    .tour_err         (tour_err),
    .state_dbg        (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected leg from the (dx,dy) table of the set bit
  function automatic logic [15:0] leg(input logic [7:0] mv, input bit vert);
    int dx = 0;
    int dy = 0;
    for (int i = 0; i < 8; i++)
      if (mv[i]) begin dx = dx_t[i]; dy = dy_t[i]; end
    if (vert)
      return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy > 0) ? dy : -dy)};
    else
      return {H_OP, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx > 0) ? dx : -dx)};
  endfunction

  task automatic serve(input string tag, input logic [15:0] exp_cmd, input logic [7:0] exp_resp);
    int t = 0;
    while (!cmd_rdy && t < 20) begin tick(); t++; end
    check({tag, "_rdy"}, 32'(cmd_rdy), 32'd1);
    check({tag, "_cmd"}, 32'(cmd), 32'(exp_cmd));
    clr_cmd_rdy = 1'b1; n_clr++;
    tick();
    clr_cmd_rdy = 1'b0;
    #1;
    check({tag, "_drop"}, 32'(cmd_rdy), 32'd0);
    check({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    send_resp = 1'b1; n_send++;
    tick();
    send_resp = 1'b0;
    #1;
  endtask

  task automatic serve_move(input int k);
    check($sformatf("indx_%0d", k), 32'(indx), 32'(k));
    serve($sformatf("v%0d", k), leg(mem[k], 1'b1), 8'h5A);
    serve($sformatf("h%0d", k), leg(mem[k], 1'b0), (k == 23) ? 8'hA5 : 8'h5A);
  endtask

  initial begin
    for (int k = 0; k < 24; k++) mem[k] = 8'h01 << ((k * 3) % 8);
    rst = 1'b1; start_tour = 1'b0; cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    tick(); tick();
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_indx", 32'(indx), 32'd0);
    check("rst_err", 32'(tour_err), 32'd0);
    check("rst_resp", 32'(resp), 32'hA5);
    check("rst_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    rst = 1'b0;
    tick();

    // Pass-through in IDLE
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; #1;
    check("pt_cmd", 32'(cmd), 32'h1234);
    check("pt_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1; #1;
    check("pt_clr", 32'(clr_cmd_rdy_UART), 32'd1);
    tick();
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0;

    // Move 0 = 8'h01, move 1 = 8'h08, directed
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0; #1;
    check("m0v_cmd", 32'(cmd), 32'h2002);
    check("m0v_rdy", 32'(cmd_rdy), 32'd1);
    check("m0v_resp", 32'(resp), 32'h5A);
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0; #1;
    check("vert_ignores_send", 32'(state_dbg), 32'(VERT));
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; cmd_rdy_UART = 1'b1; n_clr++; #1;
    check("tour_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    tick();
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_rdy_UART = 1'b0; #1;
    check("clr_wins", 32'(state_dbg), 32'(WAIT_V));
    check("wv_rdy", 32'(cmd_rdy), 32'd0);
    send_resp = 1'b1; n_send++;
    tick();
    send_resp = 1'b0; #1;
    check("m0h_cmd", 32'(cmd), 32'({H_OP, 12'hBF1}));
    check("m0h_rdy", 32'(cmd_rdy), 32'd1);
    clr_cmd_rdy = 1'b1; n_clr++;
    tick();
    clr_cmd_rdy = 1'b0; send_resp = 1'b1; n_send++;
    tick();
    send_resp = 1'b0; #1;
    check("m1_indx", 32'(indx), 32'd1);
    check("m1v_cmd", 32'(cmd), 32'h27F1);
    clr_cmd_rdy = 1'b1; n_clr++;
    tick();
    clr_cmd_rdy = 1'b0; send_resp = 1'b1; n_send++;
    tick();
    send_resp = 1'b0; #1;
    check("m1h_cmd", 32'(cmd), 32'({H_OP, 12'h3F2}));
    clr_cmd_rdy = 1'b1; n_clr++;
    tick();
    clr_cmd_rdy = 1'b0; send_resp = 1'b1; n_send++;
    tick();
    send_resp = 1'b0; #1;

    // Remainder of the tour via the responder
    for (int k = 2; k < 24; k++) serve_move(k);
    check("tour_clrs", 32'(n_clr), 32'd48);
    check("tour_sends", 32'(n_send), 32'd48);
    check("end_state", 32'(state_dbg), 32'(IDLE));
    check("end_indx", 32'(indx), 32'd0);
    check("end_resp", 32'(resp), 32'hA5);
    cmd_UART = 16'hABCD; cmd_rdy_UART = 1'b1; #1;
    check("end_pt_cmd", 32'(cmd), 32'hABCD);
    check("end_pt_rdy", 32'(cmd_rdy), 32'd1);
    cmd_rdy_UART = 1'b0;

    // Illegal move at index 5, with a stray start_tour at index 2
    mem[5] = 8'h03;
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0; #1;
    serve_move(0);
    serve_move(1);
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0; #1;
    check("midtour_start_state", 32'(state_dbg), 32'(VERT));
    check("midtour_start_indx", 32'(indx), 32'd2);
    serve_move(2);
    serve_move(3);
    serve_move(4);
    check("bad_indx", 32'(indx), 32'd5);
    check("bad_no_rdy", 32'(cmd_rdy), 32'd0);
    check("bad_err_pre", 32'(tour_err), 32'd0);
    tick();
    check("bad_err", 32'(tour_err), 32'd1);
    check("bad_state", 32'(state_dbg), 32'(IDLE));
    check("bad_indx0", 32'(indx), 32'd0);
    tick();
    check("bad_err_pulse", 32'(tour_err), 32'd0);
    mem[5] = 8'h01 << 7;

    // Reset while waiting on the vertical leg of move 10
    start_tour = 1'b1;
    tick();
    start_tour = 1'b0; #1;
    for (int k = 0; k < 10; k++) serve_move(k);
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0; #1;
    check("rst10_state", 32'(state_dbg), 32'(WAIT_V));
    check("rst10_indx", 32'(indx), 32'd10);
    rst = 1'b1; #1;
    check("rst10_async_state", 32'(state_dbg), 32'(IDLE));
    check("rst10_async_indx", 32'(indx), 32'd0);
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h5555;
    tick();
    rst = 1'b0;
    tick();
    check("rst10_pt_rdy", 32'(cmd_rdy), 32'd1);
    check("rst10_pt_cmd", 32'(cmd), 32'h5555);
    check("rst10_idle", 32'(state_dbg), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tour_cmd_player.md
# tour_cmd_player

Reader/consumer for the knight's-tour solver's move memory. After the solver signals completion, it walks move indices 0..23, reads each one-hot move, and splits it into two motion commands: a vertical leg, then a horizontal leg. It hands each command to the motion controller and waits for completion before issuing the next. When no tour is running, it passes the UART command path straight through, so it sits between the UART command receiver and the command processor.

## Interface
Parameters:
- NUM_MOVES, 24, moves read per tour; last index is NUM_MOVES-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start_tour  in  1  pulse from solver completion; ignored unless IDLE
- move  in  8  one-hot move at `indx`, from the solver's move memory
- indx  out  5  move index being read
- cmd_UART  in  16  command from UART receiver
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  acknowledge to UART receiver
- cmd  out  16  command to command processor: [15:12] opcode, [11:4] heading, [3:0] squares
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor has taken cmd
- send_resp  in  1  pulse: command processor finished the current command
- resp  out  8  response byte: 8'h5A mid-tour, 8'hA5 otherwise
- tour_err  out  1  one-cycle pulse when `move` is not one-hot

## Operation
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- Move offsets (dx,dy), +x east, +y north:
  - 01:(+1,+2), 02:(-1,+2), 04:(-2,+1), 08:(-2,-1)
  - 10:(-1,-2), 20:(+1,-2), 40:(+2,-1), 80:(+2,+1)
- Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
- Vertical leg: opcode 4'h2, heading north/south, squares |dy|.
- Horizontal leg: opcode per Configuration, heading east/west, squares |dx|.
- IDLE:
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - resp=8'hA5; indx holds 0.
  - start_tour → VERT.
- VERT: cmd=vertical leg, cmd_rdy=1. clr_cmd_rdy → WAIT_V.
- WAIT_V: cmd_rdy=0. send_resp → HORZ.
- HORZ: cmd=horizontal leg, cmd_rdy=1. clr_cmd_rdy → WAIT_H.
- WAIT_H: cmd_rdy=0. On send_resp:
  - indx==NUM_MOVES-1 → IDLE, indx←0.
  - otherwise indx←indx+1, → VERT.
- Outside IDLE:
  - clr_cmd_rdy_UART=0; cmd_rdy_UART is ignored and not acknowledged.
  - resp=8'h5A, except 8'hA5 in WAIT_H when indx==NUM_MOVES-1.
- Move not one-hot (including 0), sampled in VERT: pulse tour_err, go to IDLE, indx←0, no cmd_rdy that cycle.

## Timing
- Reset values:
  - state IDLE, indx 0, tour_err 0, resp 8'hA5, clr_cmd_rdy_UART 0.
  - cmd/cmd_rdy follow cmd_UART/cmd_rdy_UART.
- cmd, cmd_rdy, clr_cmd_rdy_UART and resp are combinational from the registered state, indx and move. indx is registered.
- start_tour in cycle N → cmd_rdy=1 with leg 0 in cycle N+1.
- clr_cmd_rdy in cycle N → cmd_rdy=0 in cycle N+1.
- send_resp in WAIT_H at cycle N → next VERT cmd valid in cycle N+1 with indx+1; `move` must settle combinationally within that cycle.
- send_resp in VERT/HORZ is ignored. send_resp together with clr_cmd_rdy takes only the clr transition.
- start_tour outside IDLE is ignored.
- rst mid-tour → IDLE, indx 0 immediately; no partial command is re-issued.
- Per tour: 48 commands, 48 clr_cmd_rdy, 48 send_resp.

## Configuration
- TOUR_CMD_FANFARE_EN defined: horizontal-leg opcode 4'h3 (move with fanfare).
- Undefined: horizontal-leg opcode 4'h2. Vertical leg is 4'h2 either way.

## Structure
- Package tour_pkg:
  - move one-hot constants
  - heading constants (N/S/E/W)
  - opcodes OP_MOVE=4'h2, OP_FANFARE=4'h3
  - state enum
  - resp constants 8'hA5/8'h5A
- Sub-module tour_move_decode (combinational): move → vert_heading, vert_sq, horz_heading, horz_sq, illegal.

## Test plan
- Reset, then cmd_rdy_UART=1, cmd_UART=16'h1234 → cmd=16'h1234, cmd_rdy=1. clr_cmd_rdy=1 → clr_cmd_rdy_UART=1.
- start_tour, move[0]=8'h01 → cmd=16'h2002. After clr and send_resp → cmd=16'h3BF1 (fanfare defined) or 16'h2BF1 (undefined).
- move 8'h08 → legs 16'h27F1 then 16'h33F2 (fanfare defined) or 16'h23F2 (undefined).
- Full 24-move tour with a responder model → 48 commands, indx 0..23. resp=8'h5A until final WAIT_H shows 8'hA5, then IDLE and pass-through restored.
- move=8'h03 at indx 5 → tour_err one-cycle pulse, IDLE, indx=0. start_tour mid-tour → no effect.
- rst asserted in WAIT_V at indx 10 → indx=0, IDLE, cmd_rdy follows cmd_rdy_UART next cycle.
